product_bcd_display: RTL and testbench

Downstream display stage for the 3x3 unsigned binary multiplier. On each completed multiplication it captures the 6-bit product and converts it to two BCD digits with a sequential shift-and-add-3 (double-dabble) engine. It then drives a time-multiplexed, active-low two-digit seven-segment display on the FPGA board. It connects directly to the multiplier's `product` and `done` outputs.

---
 rtl/product_bcd_display_pkg.sv | 37 +++
 rtl/product_bcd_display_seg7_decoder.sv | 28 ++
 rtl/product_bcd_display.sv | 168 ++++++++++++++++
 tb/tb_product_bcd_display.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/product_bcd_display_pkg.sv
// Shared definitions for the product BCD display stage: FSM states,
// active-low seven-segment patterns, field widths and the BCD adjust helper.
// Optional feature macro: PRODUCT_DISPLAY_BLANK_EN (leading-zero blanking).
package product_bcd_display_pkg;

    localparam int unsigned BCD_W   = 4;
    localparam int unsigned PROD_W  = 6;
    localparam int unsigned SHIFT_W = 2 * BCD_W + PROD_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Active-low segments, bit0=a .. bit6=g
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    // Double-dabble correction: a nibble of 5 or more gets +3 before the shift
    function automatic logic [BCD_W-1:0] bcd_adj(input logic [BCD_W-1:0] d);
        if (d >= 4'd5)
            return d + 4'd3;
        else
            return d;
    endfunction

endpackage

// File: rtl/product_bcd_display_seg7_decoder.sv
// Combinational BCD digit to active-low seven-segment decoder.
// Codes above 9 cannot occur from the converter and decode to blank.
import product_bcd_display_pkg::*;

module seg7_decoder (
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Pattern lookup for one BCD digit
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/product_bcd_display.sv
// Display stage for the 3x3 multiplier: captures the product on a rising
// edge of done, converts it to two BCD digits with a sequential
// shift-and-add-3 engine and drives a multiplexed two-digit active-low
// seven-segment display.
// Optional feature macro: PRODUCT_DISPLAY_BLANK_EN blanks a leading zero
// in the tens position.
import product_bcd_display_pkg::*;

module product_bcd_display #(
    parameter int unsigned REFRESH_BITS = 17
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PROD_W-1:0]   product,
    input  logic                done,
    output logic [6:0]          seg,
    output logic [1:0]          an,
    output logic                busy,
    output logic                updated
);

    state_t               state;
    state_t               state_nxt;

    logic                 done_d;
    logic                 capture;
    logic                 pending;
    logic [PROD_W-1:0]    pend_val;
    logic [PROD_W-1:0]    load_val;

    logic [SHIFT_W-1:0]   sreg;
    logic [SHIFT_W-1:0]   sreg_adj;
    logic [2:0]           cnt;

    logic                 load;
    logic                 shift_en;
    logic                 commit;

    logic [BCD_W-1:0]     disp_tens;
    logic [BCD_W-1:0]     disp_ones;
    logic [BCD_W-1:0]     tens_nxt;
    logic [BCD_W-1:0]     ones_nxt;

    logic [REFRESH_BITS-1:0] refresh;
    logic                 wrap;
    logic                 sel;
    logic                 sel_nxt;
    logic [BCD_W-1:0]     digit;
    logic [6:0]           dec_seg;
    logic [6:0]           seg_nxt;

    assign capture = done & ~done_d;

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic: six shifts per conversion, one commit cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (capture || pending) state_nxt = SHIFT;
            SHIFT:   if (cnt == 3'd5)        state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs and datapath controls
    always_comb begin
        busy     = (state == SHIFT) || (state == DONE);
        load     = (state == IDLE) && (capture || pending);
        shift_en = (state == SHIFT);
        commit   = (state == DONE);
        // a fresh edge in IDLE is newer than anything held pending
        load_val = capture ? product : pend_val;
    end

    // Add-3 correction on both BCD nibbles ahead of the shift
    always_comb begin
        sreg_adj = {bcd_adj(sreg[SHIFT_W-1 -: BCD_W]),
                    bcd_adj(sreg[PROD_W+BCD_W-1 -: BCD_W]),
                    sreg[PROD_W-1:0]};
    end

    // Conversion datapath, capture tracking and committed digits
    always_ff @(posedge clk) begin
        if (reset) begin
            done_d    <= 1'b0;
            pending   <= 1'b0;
            pend_val  <= '0;
            sreg      <= '0;
            cnt       <= '0;
            disp_tens <= '0;
            disp_ones <= '0;
            updated   <= 1'b0;
        end else begin
            done_d  <= done;
            updated <= commit;

            if (load) begin
                sreg    <= {{(2 * BCD_W){1'b0}}, load_val};
                cnt     <= '0;
                pending <= 1'b0;
            end else if (shift_en) begin
                sreg <= {sreg_adj[SHIFT_W-2:0], 1'b0};
                cnt  <= cnt + 3'd1;
            end

            // an edge while busy is parked; a later one overwrites it
            if (capture && (state != IDLE)) begin
                pending  <= 1'b1;
                pend_val <= product;
            end

            if (commit) begin
                disp_tens <= sreg[SHIFT_W-1 -: BCD_W];
                disp_ones <= sreg[PROD_W+BCD_W-1 -: BCD_W];
            end
        end
    end

    // Digit mux driven by next-cycle select/digits so seg/an can be registered
    always_comb begin
        wrap     = &refresh;
        sel_nxt  = sel ^ wrap;
        tens_nxt = commit ? sreg[SHIFT_W-1 -: BCD_W] : disp_tens;
        ones_nxt = commit ? sreg[PROD_W+BCD_W-1 -: BCD_W] : disp_ones;
        digit    = sel_nxt ? tens_nxt : ones_nxt;
    end

    seg7_decoder u_dec (
        .bcd (digit),
        .seg (dec_seg)
    );

    // Leading-zero blanking on the tens position when enabled
    always_comb begin
`ifdef PRODUCT_DISPLAY_BLANK_EN
        if (sel_nxt && (tens_nxt == '0))
            seg_nxt = SEG_BLANK;
        else
            seg_nxt = dec_seg;
`else
        seg_nxt = dec_seg;
`endif
    end

    // Refresh counter, digit select and registered display outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            refresh <= '0;
            sel     <= 1'b0;
            seg     <= SEG_0;
            an      <= 2'b10;
        end else begin
            refresh <= refresh + REFRESH_BITS'(1);
            sel     <= sel_nxt;
            seg     <= seg_nxt;
            an      <= sel_nxt ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: tb/tb_product_bcd_display.sv
// Directed bench for product_bcd_display with a fast refresh counter.
module tb_product_bcd_display;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] product;
    logic       done;
    logic [6:0] seg;
    logic [1:0] an;
    logic       busy;
    logic       updated;

    int total = 0;
    int bad   = 0;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000;
`ifdef PRODUCT_DISPLAY_BLANK_EN
    localparam logic [6:0] TENS_ZERO = 7'b1111111;
`else
    localparam logic [6:0] TENS_ZERO = 7'b1000000;
`endif

    product_bcd_display #(.REFRESH_BITS(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .product (product),
        .done    (done),
        .seg     (seg),
        .an      (an),
        .busy    (busy),
        .updated (updated)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) at negedges until the given digit enable is active
    task automatic wait_an(input logic [1:0] target, input string tag);
        int n = 0;
        while (an !== target && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (an !== target) check({tag, "_an_timeout"}, 32'(an), 32'(target));
    endtask

    task automatic show_check(input logic [6:0] exp_tens, input logic [6:0] exp_ones, input string tag);
        wait_an(2'b10, tag);
        check({tag, "_ones"}, 32'(seg), 32'(exp_ones));
        wait_an(2'b01, tag);
        check({tag, "_tens"}, 32'(seg), 32'(exp_tens));
    endtask

    // Capture p (done high for hold edges) and count updated pulses; i=k is after edge N+k
    task automatic run_conv(input logic [5:0] p, input int hold, input int window,
                            output int pulses, output int first);
        pulses  = 0;
        first   = -1;
        product = p;
        done    = 1'b1;
        @(posedge clk);
        for (int i = 0; i < window; i++) begin
            @(negedge clk);
            if (i == 0) check("busy_after_capture", 32'(busy), 32'd1);
            if (updated === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
            end
            if (i == hold - 1) done = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;
        int first;
        int second;

        reset   = 1'b1;
        done    = 1'b0;
        product = 6'd0;
        repeat (3) @(negedge clk);
        check("rst_an",      32'(an),      32'(2'b10));
        check("rst_seg",     32'(seg),     32'(S0));
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_updated", 32'(updated), 32'd0);
        reset = 1'b0;
        wait_an(2'b01, "rst_tens");
        check("rst_tens_seg", 32'(seg), 32'(TENS_ZERO));
        @(negedge clk);

        // 49, single-cycle pulse
        run_conv(6'd49, 1, 12, pulses, first);
        check("p49_latency", 32'(first),  32'd7);
        check("p49_pulses",  32'(pulses), 32'd1);
        show_check(S4, S9, "p49");
        @(negedge clk);

        // 63, done held 20 cycles: one conversion only
        run_conv(6'd63, 20, 30, pulses, first);
        check("p63_latency", 32'(first),  32'd7);
        check("p63_pulses",  32'(pulses), 32'd1);
        show_check(S6, S3, "p63");
        @(negedge clk);

        // 7 then 12 captured in SHIFT at edge N+3: pending conversion finishes at N+15
        pulses  = 0;
        first   = -1;
        second  = -1;
        product = 6'd7;
        done    = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (updated === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
            if (i == 7) begin
                check("p7_busy_idle", 32'(busy), 32'd0);
                if (an === 2'b10) check("p7_ones", 32'(seg), 32'(S7));
                else              check("p7_tens", 32'(seg), 32'(TENS_ZERO));
            end
            if (i == 8) check("p12_busy_start", 32'(busy), 32'd1);
            if (i == 0) done = 1'b0;
            if (i == 2) begin
                product = 6'd12;
                done    = 1'b1;
            end
            if (i == 3) done = 1'b0;
        end
        check("p7_latency",  32'(first),  32'd7);
        check("p12_latency", 32'(second), 32'd15);
        check("p7_12_pulses", 32'(pulses), 32'd2);
        show_check(S1, S2, "p12");
        @(negedge clk);

        // 36 with reset at SHIFT cycle 4: conversion and display lost
        pulses  = 0;
        product = 6'd36;
        done    = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (updated === 1'b1) pulses++;
            if (i == 0) done = 1'b0;
            if (i == 3) reset = 1'b1;
            if (i == 4) check("p36_busy_rst", 32'(busy), 32'd0);
            if (i == 5) reset = 1'b0;
        end
        check("p36_pulses", 32'(pulses), 32'd0);
        check("p36_busy",   32'(busy),   32'd0);
        show_check(TENS_ZERO, S0, "p36");
        @(negedge clk);

        // 0
        run_conv(6'd0, 1, 12, pulses, first);
        check("p0_latency", 32'(first), 32'd7);
        show_check(TENS_ZERO, S0, "p0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
